// File: rtl/mfp_sound_pkg.sv
// ============================================================================
// Module      : mfp_sound_pkg
// Description : Register map, reset values and shared types for the sound slave.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mfp_sound_pkg;

    typedef logic [2:0] sfx_id_t;
    typedef logic [2:0] reg_off_t;

    localparam reg_off_t   C_OFF_MUSIC    = 3'd0;
    localparam reg_off_t   C_OFF_VOLUME   = 3'd1;
    localparam reg_off_t   C_OFF_SFX      = 3'd2;
    localparam reg_off_t   C_OFF_STATUS   = 3'd3;

    localparam logic       C_RST_MUSIC_EN = 1'b0;
    localparam logic [3:0] C_RST_VOLUME   = 4'h8;
    localparam sfx_id_t    C_RST_SFX_ID   = 3'd0;

    function automatic logic [31:0] status_word(input logic [7:0] cnt,
                                                input logic       pending,
                                                input logic       busy);
        return {16'h0000, cnt, 6'b000000, pending, busy};
    endfunction

endpackage

`default_nettype wire

// File: rtl/mfp_sound_sfx_arbiter.sv
// ============================================================================
// Module      : mfp_sound_sfx_arbiter
// Description : Holds a pending sound-effect request and issues it as a
//               one-cycle trigger once the generator is idle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mfp_sound_sfx_arbiter
    import mfp_sound_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_i,
    input  sfx_id_t          wr_id_i,
    input  logic             busy_i,
    output logic             pending_o,
    output sfx_id_t          pending_id_o,
    output logic             trig_o,
    output sfx_id_t          id_o,
    output logic [CNT_W-1:0] count_o
);

    logic             pending_q, pending_d;
    sfx_id_t          pending_id_q, pending_id_d;
    logic             trig_q, trig_d;
    sfx_id_t          id_q, id_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             w_issue;

    assign w_issue = pending_q & ~busy_i;

    always_comb begin
        pending_d    = pending_q;
        pending_id_d = pending_id_q;
        trig_d       = 1'b0;
        id_d         = id_q;
        count_d      = count_q;
        if (w_issue) begin
            trig_d    = 1'b1;
            id_d      = pending_id_q;
            pending_d = 1'b0;
            count_d   = count_q + CNT_W'(1);
        end
        // A write landing on the issue edge queues behind the effect being issued
        if (wr_i) begin
            pending_d    = 1'b1;
            pending_id_d = wr_id_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q    <= 1'b0;
            pending_id_q <= C_RST_SFX_ID;
            trig_q       <= 1'b0;
            id_q         <= C_RST_SFX_ID;
            count_q      <= '0;
        end else begin
            pending_q    <= pending_d;
            pending_id_q <= pending_id_d;
            trig_q       <= trig_d;
            id_q         <= id_d;
            count_q      <= count_d;
        end
    end

    assign pending_o    = pending_q;
    assign pending_id_o = pending_id_q;
    assign trig_o       = trig_q;
    assign id_o         = id_q;
    assign count_o      = count_q;

endmodule

`default_nettype wire

// File: rtl/mfp_ahb_sound_slave.sv
// ============================================================================
// Module      : mfp_ahb_sound_slave
// Description : Zero-wait-state AHB-Lite slave exposing the sound controls and
//               sound-effect status as readable/writable registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mfp_ahb_sound_slave
    import mfp_sound_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP,
    input  logic        SFX_BUSY,
    output logic        SOUND_MUSIC_EN,
    output logic [3:0]  SOUND_VOLUME,
    output logic [2:0]  SFX_ID,
    output logic        SFX_TRIG
);

    reg_off_t         addr_q;
    logic             write_q;
    logic             dphase_q;
    logic             music_q;
    logic [3:0]       volume_q;
    logic [31:0]      hrdata_q;

    logic             w_accept;
    logic             w_wr_en;
    logic             w_wr_music;
    logic             w_wr_volume;
    logic             w_wr_sfx;
    logic             w_fwd;
    logic [31:0]      w_rdata;
    logic             w_pending;
    sfx_id_t          w_pending_id;
    logic [CNT_W-1:0] w_count;
    logic             w_unused_ok;

    assign w_accept    = HSEL & HTRANS[1];
    assign w_wr_en     = dphase_q & write_q;
    assign w_wr_music  = w_wr_en & (addr_q == C_OFF_MUSIC);
    assign w_wr_volume = w_wr_en & (addr_q == C_OFF_VOLUME);
    assign w_wr_sfx    = w_wr_en & (addr_q == C_OFF_SFX);
    // Read overlapping a write's data phase to the same word sees the new value
    assign w_fwd       = w_wr_en & (addr_q == HADDR[4:2]);

    always_comb begin
        w_rdata = '0;
        case (HADDR[4:2])
            C_OFF_MUSIC:  w_rdata = {31'h0, (w_fwd ? HWDATA[0] : music_q)};
            C_OFF_VOLUME: w_rdata = {28'h0, (w_fwd ? HWDATA[3:0] : volume_q)};
            C_OFF_SFX:    w_rdata = w_fwd ? {1'b1, 28'h0, HWDATA[2:0]}
                                          : {w_pending, 28'h0, w_pending_id};
            C_OFF_STATUS: w_rdata = status_word(8'(w_count), w_pending, SFX_BUSY);
            default:      w_rdata = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            addr_q   <= '0;
            write_q  <= 1'b0;
            dphase_q <= 1'b0;
            music_q  <= C_RST_MUSIC_EN;
            volume_q <= C_RST_VOLUME;
            hrdata_q <= '0;
        end else begin
            addr_q   <= HADDR[4:2];
            write_q  <= HWRITE;
            dphase_q <= w_accept;
            if (w_wr_music) begin
                music_q <= HWDATA[0];
            end
            if (w_wr_volume) begin
                volume_q <= HWDATA[3:0];
            end
            if (w_accept && !HWRITE) begin
                hrdata_q <= w_rdata;
            end
        end
    end

    mfp_sound_sfx_arbiter #(
        .CNT_W (CNT_W)
    ) u_sfx (
        .clk_i        (CLK),
        .rst_ni       (RESETn),
        .wr_i         (w_wr_sfx),
        .wr_id_i      (HWDATA[2:0]),
        .busy_i       (SFX_BUSY),
        .pending_o    (w_pending),
        .pending_id_o (w_pending_id),
        .trig_o       (SFX_TRIG),
        .id_o         (SFX_ID),
        .count_o      (w_count)
    );

    assign HRDATA         = hrdata_q;
    assign HREADY         = 1'b1;
    assign HRESP          = 1'b0;
    assign SOUND_MUSIC_EN = music_q;
    assign SOUND_VOLUME   = volume_q;

    assign w_unused_ok = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA[31:4]};

endmodule

`default_nettype wire

// File: tb/tb_mfp_ahb_sound_slave.sv
// ============================================================================
// Module      : tb_mfp_ahb_sound_slave
// Description : Directed bench for the AHB sound slave, with a register-level
//               model compared every cycle plus hand-computed checkpoints.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mfp_ahb_sound_slave;

    logic        CLK;
    logic        RESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic        SFX_BUSY;
    logic        SOUND_MUSIC_EN;
    logic [3:0]  SOUND_VOLUME;
    logic [2:0]  SFX_ID;
    logic        SFX_TRIG;

    int          vectors;
    int          miscompares;
    int          trig_pulses;
    int          t0;
    bit          run;
    logic [31:0] wd_next;

    // Model of the software-visible state
    logic        m_music;
    logic [3:0]  m_vol;
    logic        m_pending;
    logic [2:0]  m_pid;
    logic [2:0]  m_id;
    logic        m_trig;
    logic [7:0]  m_count;
    logic [31:0] m_hrdata;
    logic        m_dp_valid;
    logic        m_dp_write;
    logic [2:0]  m_dp_addr;
    logic        m_sfx_wr;
    logic        m_issue;

    mfp_ahb_sound_slave #(
        .CNT_W (8)
    ) dut (
        .CLK            (CLK),
        .RESETn         (RESETn),
        .HSEL           (HSEL),
        .HADDR          (HADDR),
        .HTRANS         (HTRANS),
        .HWRITE         (HWRITE),
        .HWDATA         (HWDATA),
        .HRDATA         (HRDATA),
        .HREADY         (HREADY),
        .HRESP          (HRESP),
        .SFX_BUSY       (SFX_BUSY),
        .SOUND_MUSIC_EN (SOUND_MUSIC_EN),
        .SOUND_VOLUME   (SOUND_VOLUME),
        .SFX_ID         (SFX_ID),
        .SFX_TRIG       (SFX_TRIG)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // What a read of word 'off' must return, including a write about to commit
    function automatic logic [31:0] readable(input logic [2:0] off);
        logic [31:0] regs [0:7];
        foreach (regs[i]) regs[i] = 32'h0;
        regs[0] = {31'h0, m_music};
        regs[1] = {28'h0, m_vol};
        regs[2] = {m_pending, 28'h0, m_pid};
        regs[3] = {16'h0, m_count, 6'h0, m_pending, SFX_BUSY};
        if (m_dp_valid && m_dp_write) begin
            case (m_dp_addr)
                3'd0:    regs[0] = {31'h0, HWDATA[0]};
                3'd1:    regs[1] = {28'h0, HWDATA[3:0]};
                3'd2:    regs[2] = {1'b1, 28'h0, HWDATA[2:0]};
                default: ;
            endcase
        end
        return regs[off];
    endfunction

    assign m_sfx_wr = m_dp_valid && m_dp_write && (m_dp_addr == 3'd2);
    assign m_issue  = m_pending && !SFX_BUSY;

    always @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            m_music    <= 1'b0;
            m_vol      <= 4'h8;
            m_pending  <= 1'b0;
            m_pid      <= 3'd0;
            m_id       <= 3'd0;
            m_trig     <= 1'b0;
            m_count    <= 8'd0;
            m_hrdata   <= 32'h0;
            m_dp_valid <= 1'b0;
            m_dp_write <= 1'b0;
            m_dp_addr  <= 3'd0;
        end else begin
            m_dp_valid <= HSEL && HTRANS[1];
            m_dp_write <= HWRITE;
            m_dp_addr  <= HADDR[4:2];
            if (HSEL && HTRANS[1] && !HWRITE) m_hrdata <= readable(HADDR[4:2]);
            if (m_dp_valid && m_dp_write && m_dp_addr == 3'd0) m_music <= HWDATA[0];
            if (m_dp_valid && m_dp_write && m_dp_addr == 3'd1) m_vol <= HWDATA[3:0];
            m_trig <= m_issue;
            if (m_issue) begin
                m_id    <= m_pid;
                m_count <= m_count + 8'd1;
            end
            if (m_sfx_wr) begin
                m_pending <= 1'b1;
                m_pid     <= HWDATA[2:0];
            end else if (m_issue) begin
                m_pending <= 1'b0;
            end
        end
    end

    always @(negedge CLK) begin
        if (run) begin
            chk("HRDATA",         HRDATA,                m_hrdata);
            chk("SOUND_MUSIC_EN", 32'(SOUND_MUSIC_EN),   32'(m_music));
            chk("SOUND_VOLUME",   32'(SOUND_VOLUME),     32'(m_vol));
            chk("SFX_ID",         32'(SFX_ID),           32'(m_id));
            chk("SFX_TRIG",       32'(SFX_TRIG),         32'(m_trig));
            chk("HREADY",         32'(HREADY),           32'h1);
            chk("HRESP",          32'(HRESP),            32'h0);
            if (SFX_TRIG === 1'b1) trig_pulses++;
        end
    end

    // One bus cycle: new address phase, plus data for the previous one
    task automatic step(input bit sel, input bit wr, input logic [2:0] off, input logic [31:0] wd);
        @(posedge CLK);
        #1;
        HWDATA  = wd_next;
        wd_next = wd;
        HSEL    = sel;
        HTRANS  = sel ? 2'b10 : 2'b00;
        HWRITE  = wr;
        HADDR   = {27'h0, off, 2'b00};
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 3'd0, 32'h0);
    endtask

    initial begin
        logic [31:0] rst_exp [0:3];
        rst_exp[0] = 32'h0; rst_exp[1] = 32'h8; rst_exp[2] = 32'h0; rst_exp[3] = 32'h0;
        CLK = 1'b0; RESETn = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
        HADDR = 32'h0; HWDATA = 32'h0; SFX_BUSY = 1'b0; wd_next = 32'h0;
        vectors = 0; miscompares = 0; trig_pulses = 0; run = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESETn = 1'b1;

        chk("lit_rst_music", 32'(SOUND_MUSIC_EN), 32'h0);
        chk("lit_rst_vol",   32'(SOUND_VOLUME),   32'h8);
        chk("lit_rst_hrdata", HRDATA,             32'h0);

        step(1'b1, 1'b0, 3'd0, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            if (i < 4) step(1'b1, 1'b0, 3'(i), 32'h0);
            else       idle(1);
            chk("lit_rst_read", HRDATA, rst_exp[i-1]);
        end

        step(1'b1, 1'b1, 3'd0, 32'h1);
        step(1'b1, 1'b1, 3'd1, 32'h3);
        chk("lit_music_n1", 32'(SOUND_MUSIC_EN), 32'h0);
        idle(1);
        chk("lit_music_n2", 32'(SOUND_MUSIC_EN), 32'h1);
        step(1'b1, 1'b0, 3'd0, 32'h0);
        chk("lit_vol", 32'(SOUND_VOLUME), 32'h3);
        step(1'b1, 1'b0, 3'd1, 32'h0);
        chk("lit_rd_music", HRDATA, 32'h1);
        idle(1);
        chk("lit_rd_vol", HRDATA, 32'h3);

        step(1'b1, 1'b1, 3'd2, 32'h5);
        idle(1);
        chk("lit_trig_n1", 32'(SFX_TRIG), 32'h0);
        idle(1);
        chk("lit_trig_n2", 32'(SFX_TRIG), 32'h0);
        idle(1);
        chk("lit_trig_n3", 32'(SFX_TRIG), 32'h1);
        chk("lit_id_5",    32'(SFX_ID),   32'h5);
        idle(1);
        chk("lit_trig_n4", 32'(SFX_TRIG), 32'h0);
        step(1'b1, 1'b0, 3'd3, 32'h0);
        idle(1);
        chk("lit_status_cnt1", HRDATA, 32'h0000_0100);

        SFX_BUSY = 1'b1;
        t0 = trig_pulses;
        step(1'b1, 1'b1, 3'd2, 32'h2);
        step(1'b1, 1'b1, 3'd2, 32'h6);
        idle(2);
        step(1'b1, 1'b0, 3'd2, 32'h0);
        idle(1);
        chk("lit_sfx_pending", HRDATA, 32'h8000_0006);
        idle(3);
        chk("lit_busy_notrig", 32'(trig_pulses - t0), 32'h0);
        SFX_BUSY = 1'b0;
        idle(4);
        chk("lit_busy_onetrig", 32'(trig_pulses - t0), 32'h1);
        chk("lit_id_6",         32'(SFX_ID),          32'h6);

        step(1'b1, 1'b1, 3'd1, 32'hA);
        step(1'b1, 1'b0, 3'd1, 32'h0);
        idle(1);
        chk("lit_fwd_vol", HRDATA, 32'h0000_000A);
        step(1'b1, 1'b1, 3'd3, 32'hFFFF);
        step(1'b1, 1'b0, 3'd3, 32'h0);
        idle(1);
        chk("lit_status_ro_a", HRDATA, 32'h0000_0200);
        step(1'b1, 1'b0, 3'd3, 32'h0);
        idle(1);
        chk("lit_status_ro_b", HRDATA, 32'h0000_0200);
        step(1'b1, 1'b0, 3'd5, 32'h0);
        idle(1);
        chk("lit_rd_off5", HRDATA, 32'h0);

        SFX_BUSY = 1'b1;
        step(1'b1, 1'b1, 3'd2, 32'h3);
        idle(2);
        t0 = trig_pulses;
        step(1'b1, 1'b1, 3'd2, 32'h4);
        idle(1);
        SFX_BUSY = 1'b0;
        idle(1);
        chk("lit_coll_trig_a", 32'(SFX_TRIG), 32'h1);
        chk("lit_coll_id_a",   32'(SFX_ID),   32'h3);
        idle(1);
        chk("lit_coll_trig_b", 32'(SFX_TRIG), 32'h1);
        chk("lit_coll_id_b",   32'(SFX_ID),   32'h4);
        idle(1);
        chk("lit_coll_count", 32'(trig_pulses - t0), 32'h2);

        for (int i = 0; i < 252; i++) begin
            step(1'b1, 1'b1, 3'd2, 32'(i % 8));
            idle(3);
        end
        step(1'b1, 1'b0, 3'd3, 32'h0);
        idle(1);
        chk("lit_count_wrap", HRDATA, 32'h0);
        chk("lit_wrap_id",    32'(SFX_ID), 32'h3);

        step(1'b1, 1'b0, 3'd1, 32'h0);
        step(1'b1, 1'b1, 3'd1, 32'h5);
        chk("lit_pre_rst_hrdata", HRDATA, 32'h0000_000A);
        idle(1);
        #2;
        RESETn = 1'b0;
        #1;
        chk("lit_mid_rst_vol",    32'(SOUND_VOLUME),   32'h8);
        chk("lit_mid_rst_music",  32'(SOUND_MUSIC_EN), 32'h0);
        chk("lit_mid_rst_hrdata", HRDATA,              32'h0);
        chk("lit_mid_rst_id",     32'(SFX_ID),         32'h0);
        chk("lit_mid_rst_trig",   32'(SFX_TRIG),       32'h0);
        @(posedge CLK);
        @(negedge CLK);
        RESETn = 1'b1;
        idle(2);
        chk("lit_post_rst_vol",   32'(SOUND_VOLUME),   32'h8);
        chk("lit_post_rst_music", 32'(SOUND_MUSIC_EN), 32'h0);

        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mfp_ahb_sound_slave.md
# mfp_ahb_sound_slave

AHB-Lite slave for the sound peripheral: full read/write register access to the sound controls, plus status readback from the sound generator. Sits on the AHB-Lite bus behind the system address decoder (which supplies HSEL). Drives music enable, volume and one-shot sound-effect triggers into the sound generator. Makes every sound register software-readable, so the CPU can read back music state and effect status instead of tracking it in shadow variables.

## Interface
Parameters:
- CNT_W, 8, width of the sound-effect issue counter.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RESETn  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select from the address decoder.
- HADDR  in  32  byte address; only HADDR[4:2] is decoded.
- HTRANS  in  2  transfer type; HTRANS[1]=1 means NONSEQ/SEQ (valid).
- HWRITE  in  1  1 = write.
- HWDATA  in  32  write data, valid in the data phase.
- HRDATA  out  32  read data, valid in the data phase.
- HREADY  out  1  constant 1 (zero wait state).
- HRESP  out  1  constant 0 (OKAY).
- SFX_BUSY  in  1  sound generator is playing an effect.
- SOUND_MUSIC_EN  out  1  music enable to the sound generator.
- SOUND_VOLUME  out  4  master volume.
- SFX_ID  out  3  effect ID of the most recent trigger.
- SFX_TRIG  out  1  one-cycle effect start pulse.

## Operation
- Accepted transfer: HSEL & HTRANS[1] in the address phase. The address phase registers HADDR[4:2] and HWRITE, and sets a data-phase valid flag.
- Register map, by word offset (constants in the package):
  - 0 MUSIC, RW: bit0 = music enable. Reset 0.
  - 1 VOLUME, RW: bits[3:0]. Reset 4'h8.
  - 2 SFX, RW:
    - A write latches bits[2:0] as the pending ID and sets the pending flag.
    - A read returns {pending, 28'b0, pending_id} with pending in bit31. Reset 0.
  - 3 STATUS, RO: {16'b0, count[7:0], 6'b0, pending, SFX_BUSY}. Writes are ignored.
  - 4–7: reads return 0; writes are ignored.
- Writes commit on the clock edge that ends the data phase, using HWDATA.
- Reads: HRDATA is registered on the edge that ends the address phase. It holds until the next accepted read, and is 0 after reset.
- Read-after-write forwarding: if a read's address phase overlaps a write's data phase to the same offset, HRDATA returns the value the write is about to commit (built from HWDATA). It never returns the stale value.
- Effect trigger:
  - Each cycle, if pending=1 and SFX_BUSY=0: on the next edge SFX_TRIG=1 for one cycle, SFX_ID=pending_id, pending clears, and count increments (wraps 8'hFF→0).
  - Multiple SFX writes while pending: the last ID wins and only one trigger is issued.
  - SFX write committing on the same edge the trigger issues: the old ID is issued, and pending stays 1 with the new ID.
- Reset mid-transfer: all state clears immediately and the in-flight data phase is dropped.
- Reset values: SOUND_MUSIC_EN=0, SOUND_VOLUME=8, SFX_ID=0, SFX_TRIG=0, HRDATA=0, pending=0, count=0.

## Timing
- Address phase in cycle N; write commits at the end of N+1. SOUND_MUSIC_EN and SOUND_VOLUME change in N+2.
- SFX write (address phase N) makes pending=1 in N+2. If SFX_BUSY=0 in N+2, SFX_TRIG=1 in N+3.
- While SFX_BUSY=1, pending holds indefinitely. SFX_TRIG fires in the cycle after the first cycle with SFX_BUSY=0.
- Back-to-back transfers, one per cycle, are supported with no bubbles.
- HREADY=1 always; no wait states, no error responses.

## Structure
- The package mfp_sound_pkg holds:
  - register offset constants (MUSIC, VOLUME, SFX, STATUS);
  - reset values;
  - the effect-ID typedef (logic [2:0]).
- Sub-module mfp_sound_sfx_arbiter holds the pending flag and ID, the SFX_TRIG/SFX_ID register and the issue counter.
  - Inputs: write strobe, write ID, SFX_BUSY.
  - Outputs: pending, pending_id, trig, id, count.
- The top level holds the AHB address/data-phase pipeline, the register file, the read mux and the forwarding path.

## Test plan
- Reset release, then read offsets 0–3 → 0, 8, 0, 0. SOUND_MUSIC_EN=0, SOUND_VOLUME=8.
- Write MUSIC=1 and VOLUME=0x3, then read both back → SOUND_MUSIC_EN=1 two cycles after the address phase, SOUND_VOLUME=3, reads return 1 and 3.
- Write SFX=5 with SFX_BUSY=0 → single SFX_TRIG pulse 3 cycles after the address phase, SFX_ID=5, STATUS count=1.
- Hold SFX_BUSY=1 and write SFX=2 then SFX=6 → no trigger. SFX read returns 0x80000006. Drop SFX_BUSY → exactly one trigger with SFX_ID=6.
- Back-to-back write VOLUME=0xA then read VOLUME in the next cycle → HRDATA=0xA (forwarded). Then write STATUS=0xFFFF → STATUS is unchanged.
- Issue 256 triggers → count wraps to 0. Assert RESETn low mid write data phase → write dropped, all outputs at their reset values.
